// File: rtl/pcpi_approx_mul_pkg.sv
// rtl/pcpi_approx_mul_pkg.sv - decode constants, FSM encoding and iteration-count helper
package pcpi_defs;

   localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
   localparam logic [6:0] F7_APPROX   = 7'b0000001;
   localparam logic [2:0] F3_MULA     = 3'b000;
   localparam logic [2:0] F3_MULHUA   = 3'b011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Shift-add iterations needed to retire the untruncated multiplier bits.
   function automatic int calc_iters(input int trunc_bits, input int step);
      return (32 - trunc_bits + step - 1) / step;
   endfunction

endpackage

// File: rtl/pcpi_approx_mul_core.sv
// rtl/pcpi_approx_mul_core.sv - operand truncation plus iterative shift-add multiplier
module approx_mul_core
   import pcpi_defs::*;
#(
   parameter int TRUNC_BITS = 4,
   parameter int STEP       = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [63:0] product
);

   localparam int          N      = calc_iters(TRUNC_BITS, STEP);
   localparam logic [5:0]  N_INIT = 6'(N);
   localparam logic [31:0] MASK   = 32'hFFFF_FFFF << TRUNC_BITS;

   logic [63:0] acc;
   logic [63:0] mcand;
   logic [31:0] mplr;
   logic [5:0]  cnt;
   logic [63:0] sum;

   // product carries this cycle's partial products, so it is final while done is high.
   always_comb begin
      sum = acc;
      for (int k = 0; k < STEP; k++) begin
         if (mplr[k])
            sum = sum + (mcand << k);
      end
   end

   assign done    = busy && (cnt == 6'd1);
   assign product = sum;

   always_ff @(posedge clk) begin
      if (reset) begin
         acc   <= '0;
         mcand <= '0;
         mplr  <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
      end else if (start) begin
         acc   <= '0;
         mcand <= {32'd0, a & MASK} << TRUNC_BITS;
         mplr  <= (b & MASK) >> TRUNC_BITS;
         cnt   <= N_INIT;
         busy  <= 1'b1;
      end else if (busy) begin
         acc   <= sum;
         mcand <= mcand << STEP;
         mplr  <= mplr >> STEP;
         cnt   <= cnt - 6'd1;
         if (cnt == 6'd1)
            busy <= 1'b0;
      end
   end

endmodule

// File: rtl/pcpi_approx_mul.sv
// rtl/pcpi_approx_mul.sv - PCPI decode, FSM and handshake around the approximate multiplier
module pcpi_approx_mul
   import pcpi_defs::*;
#(
   parameter int TRUNC_BITS = 4,
   parameter int STEP       = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pcpi_valid,
   input  logic [31:0] pcpi_insn,
   input  logic [31:0] pcpi_rs1,
   input  logic [31:0] pcpi_rs2,
   output logic        pcpi_wr,
   output logic [31:0] pcpi_rd,
   output logic        pcpi_wait,
   output logic        pcpi_ready
);

   state_t      state;
   logic        sel_hi;
   logic        match;
   logic        accept;
   logic        core_busy;
   logic        core_done;
   logic [63:0] core_product;
   logic [2:0]  funct3;
   logic        unused_fields;

   assign funct3        = pcpi_insn[14:12];
   assign unused_fields = &{1'b0, pcpi_insn[24:15], pcpi_insn[11:7]};

   assign match = (pcpi_insn[6:0] == OPC_CUSTOM0) &&
                  (pcpi_insn[31:25] == F7_APPROX) &&
                  ((funct3 == F3_MULA) || (funct3 == F3_MULHUA));

   assign accept = (state == IDLE) && pcpi_valid && match && !pcpi_ready;

   approx_mul_core #(
      .TRUNC_BITS(TRUNC_BITS),
      .STEP      (STEP)
   ) u_core (
      .clk    (clk),
      .reset  (reset),
      .start  (accept),
      .a      (pcpi_rs1),
      .b      (pcpi_rs2),
      .busy   (core_busy),
      .done   (core_done),
      .product(core_product)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         sel_hi     <= 1'b0;
         pcpi_wr    <= 1'b0;
         pcpi_rd    <= '0;
         pcpi_wait  <= 1'b0;
         pcpi_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               pcpi_wr    <= 1'b0;
               pcpi_rd    <= '0;
               pcpi_ready <= 1'b0;
               if (accept) begin
                  sel_hi    <= (funct3 == F3_MULHUA);
                  pcpi_wait <= 1'b1;
                  state     <= CALC;
               end
            end
            CALC: begin
               // A dropped request abandons the multiply; the core is simply restarted later.
               if (!pcpi_valid || !core_busy) begin
                  pcpi_wait <= 1'b0;
                  state     <= IDLE;
               end else if (core_done) begin
                  pcpi_wait  <= 1'b0;
                  pcpi_ready <= 1'b1;
                  pcpi_wr    <= 1'b1;
                  pcpi_rd    <= sel_hi ? core_product[63:32] : core_product[31:0];
                  state      <= DONE;
               end
            end
            DONE: begin
               pcpi_ready <= 1'b0;
               pcpi_wr    <= 1'b0;
               pcpi_rd    <= '0;
               state      <= IDLE;
            end
            default: begin
               pcpi_wait  <= 1'b0;
               pcpi_ready <= 1'b0;
               pcpi_wr    <= 1'b0;
               pcpi_rd    <= '0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pcpi_approx_mul.sv
// tb/tb_pcpi_approx_mul.sv - directed scoreboard bench: TRUNC=4/STEP=1 and TRUNC=0/STEP=4 instances
module tb_pcpi_approx_mul;

   logic        clk = 1'b0;
   logic        reset;
   logic        v    [2];
   logic [31:0] insn [2];
   logic [31:0] rs1  [2];
   logic [31:0] rs2  [2];
   logic        wr   [2];
   logic [31:0] rd   [2];
   logic        wt   [2];
   logic        rdy  [2];

   logic [31:0] q0 [$];
   logic [31:0] q1 [$];

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] MULA   = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0001011};
   localparam logic [31:0] MULHUA = {7'b0000001, 5'd2, 5'd1, 3'b011, 5'd3, 7'b0001011};
   localparam logic [31:0] BAD_F3 = {7'b0000001, 5'd2, 5'd1, 3'b001, 5'd3, 7'b0001011};
   localparam logic [31:0] BAD_OP = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};

   always #5 clk = ~clk;

   pcpi_approx_mul #(.TRUNC_BITS(4), .STEP(1)) dut0 (
      .clk(clk), .reset(reset), .pcpi_valid(v[0]), .pcpi_insn(insn[0]),
      .pcpi_rs1(rs1[0]), .pcpi_rs2(rs2[0]), .pcpi_wr(wr[0]), .pcpi_rd(rd[0]),
      .pcpi_wait(wt[0]), .pcpi_ready(rdy[0])
   );

   pcpi_approx_mul #(.TRUNC_BITS(0), .STEP(4)) dut1 (
      .clk(clk), .reset(reset), .pcpi_valid(v[1]), .pcpi_insn(insn[1]),
      .pcpi_rs1(rs1[1]), .pcpi_rs2(rs2[1]), .pcpi_wr(wr[1]), .pcpi_rd(rd[1]),
      .pcpi_wait(wt[1]), .pcpi_ready(rdy[1])
   );

   function automatic logic [31:0] model(input int t, input bit hi,
                                         input logic [31:0] a, input logic [31:0] b);
      logic [31:0] m;
      logic [63:0] p;
      m = 32'hFFFF_FFFF << t;
      p = 64'(a & m) * 64'(b & m);
      return hi ? p[63:32] : p[31:0];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int d, input logic [31:0] e);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic run(input int d, input logic [31:0] ins, input logic [31:0] a,
                      input logic [31:0] b, input int lat, input string tag);
      int          cyc;
      bit          got;
      logic [31:0] e;
      @(negedge clk);
      v[d] = 1'b1; insn[d] = ins; rs1[d] = a; rs2[d] = b;
      cyc = 0; got = 1'b0;
      while (!got && cyc < lat + 10) begin
         @(posedge clk); cyc++; @(negedge clk);
         if (cyc == 1) check({tag, "_wait_c1"}, 64'(wt[d]), 64'd1);
         if (rdy[d]) got = 1'b1;
      end
      v[d] = 1'b0;
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      check({tag, "_ready_seen"}, 64'(got), 64'd1);
      if (got) begin
         check({tag, "_rd"}, 64'(rd[d]), 64'(e));
         check({tag, "_wr"}, 64'(wr[d]), 64'd1);
         check({tag, "_wait_at_ready"}, 64'(wt[d]), 64'd0);
         check({tag, "_latency"}, 64'(cyc), 64'(lat));
      end
      @(posedge clk); @(negedge clk);
      check({tag, "_ready_1cyc"}, {31'd0, rdy[d], rd[d]}, 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int hits;
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         v[d] = 1'b0; insn[d] = '0; rs1[d] = '0; rs2[d] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++)
         check($sformatf("reset_outs%0d", d), {30'd0, wr[d], wt[d], rdy[d], rd[d]}, 64'd0);
      reset = 1'b0;

      push(0, 32'h0001_2300);
      run(0, MULA, 32'h0000_1234, 32'h0000_0010, 29, "t4_mula");
      push(0, 32'hFFFF_FFE0);
      run(0, MULHUA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 29, "t4_mulhua_ones");
      push(0, 32'h0000_0100);
      run(0, MULA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 29, "t4_mula_ones");

      push(1, 32'h0002_0001);
      run(1, MULA, 32'h0001_0001, 32'h0001_0001, 9, "t0_mula");
      push(1, 32'h0000_0001);
      run(1, MULHUA, 32'h0001_0001, 32'h0001_0001, 9, "t0_mulhua");

      push(0, model(4, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678));
      run(0, MULA, 32'hDEAD_BEEF, 32'h1234_5678, 29, "t4_mula_mix");
      push(1, model(0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678));
      run(1, MULHUA, 32'hDEAD_BEEF, 32'h1234_5678, 9, "t0_mulhua_mix");

      // Non-matching instructions held valid must never be acknowledged.
      hits = 0;
      @(negedge clk);
      v[0] = 1'b1; insn[0] = BAD_F3; v[1] = 1'b1; insn[1] = BAD_OP;
      repeat (20) begin
         @(posedge clk); @(negedge clk);
         hits += int'(wt[0]) + int'(rdy[0]) + int'(wt[1]) + int'(rdy[1]);
      end
      v[0] = 1'b0; v[1] = 1'b0;
      check("illegal_no_response", 64'(hits), 64'd0);

      // Abort: valid dropped during CALC cycle 10.
      hits = 0;
      @(negedge clk);
      v[0] = 1'b1; insn[0] = MULA; rs1[0] = 32'h0000_0100; rs2[0] = 32'h0000_0300;
      for (int c = 1; c <= 35; c++) begin
         @(posedge clk); @(negedge clk);
         if (c == 10) v[0] = 1'b0;
         if (c == 12) check("abort_wait_low", 64'(wt[0]), 64'd0);
         hits += int'(rdy[0]);
      end
      check("abort_no_ready", 64'(hits), 64'd0);
      push(0, 32'h0003_0000);
      run(0, MULA, 32'h0000_0100, 32'h0000_0300, 29, "after_abort");

      // Reset during CALC cycle 5.
      @(negedge clk);
      v[0] = 1'b1; insn[0] = MULHUA; rs1[0] = 32'h8765_4321; rs2[0] = 32'hFEDC_BA98;
      repeat (5) begin @(posedge clk); @(negedge clk); end
      check("pre_reset_wait", 64'(wt[0]), 64'd1);
      reset = 1'b1; v[0] = 1'b0;
      @(posedge clk); @(negedge clk);
      check("midcalc_reset_outs", {30'd0, wr[0], wt[0], rdy[0], rd[0]}, 64'd0);
      reset = 1'b0;
      push(0, model(4, 1'b1, 32'h8765_4321, 32'hFEDC_BA98));
      run(0, MULHUA, 32'h8765_4321, 32'hFEDC_BA98, 29, "after_reset");

      check("scoreboard_empty", 64'(q0.size() + q1.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pcpi_approx_mul.md
Name: pcpi_approx_mul

Overview:
- PCPI co-processor on the core's PCPI bus. Executes a custom approximate-multiply instruction.
- Sits directly downstream of the CPU wrapper's PCPI request outputs (valid/insn/rs1/rs2). Its wr/rd/wait/ready drive the wrapper's pcpi_approx_mul_* inputs.
- Approximation is operand LSB truncation: the low TRUNC_BITS of both operands are zeroed before an iterative shift-add multiply.
- TRUNC_BITS=0 gives exact results.

Parameters:
- TRUNC_BITS, 4, operand LSBs forced to zero; legal 0..16.
- STEP, 1, multiplier bits retired per CALC cycle; legal 1, 2, 4.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- pcpi_valid  in  1  CPU request valid; held until ready or abort
- pcpi_insn  in  32  instruction word
- pcpi_rs1  in  32  operand A
- pcpi_rs2  in  32  operand B
- pcpi_wr  out  1  write rd; high only with pcpi_ready
- pcpi_rd  out  32  result; 0 when pcpi_ready=0
- pcpi_wait  out  1  busy, suppresses the CPU illegal-insn timeout
- pcpi_ready  out  1  single-cycle completion strobe

Behaviour:
- Reset: state=IDLE; pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready all 0; internal accumulators 0. Reset wins over every other event, including mid-CALC.
- Decode match requires all of:
  - insn[6:0]=7'b0001011 (custom-0)
  - insn[31:25]=7'b0000001
  - insn[14:12] is 3'b000 (MULA, low word) or 3'b011 (MULHUA, high word, unsigned)
- Any other insn: no response at all (wait/ready stay 0).
- mask = ~((1<<TRUNC_BITS)-1); a = rs1 & mask; b = rs2 & mask.
- Result: 64-bit unsigned product P = a*b. MULA returns P[31:0]; MULHUA returns P[63:32].
- N = ceil((32-TRUNC_BITS)/STEP) iterations.
  - Multiplier starts as b>>TRUNC_BITS; multiplicand starts as a<<TRUNC_BITS (64-bit).
  - Each cycle adds STEP partial products, then shifts.
- States:
  - IDLE: accept when pcpi_valid && match && !pcpi_ready. Latch a, b and sel_hi; clear acc; load counter=N → CALC.
  - CALC: pcpi_wait=1 (registered, so first high the cycle after accept). Counter decrements each cycle. At counter 1 → DONE. If pcpi_valid drops → abort to IDLE, no ready, wait cleared next cycle.
  - DONE: pcpi_ready=1, pcpi_wr=1, pcpi_rd=selected word, pcpi_wait=0, for exactly one cycle → IDLE.
- Latency: accept at cycle 0, wait high cycles 1..N, ready at cycle N+1. Defaults N=28, so ready at cycle 29.
- Default wait rise at cycle 1 is well inside the 16-cycle PCPI timeout.
- No back-to-back acceptance in the cycle after DONE: the !pcpi_ready guard plus the CPU dropping valid covers it.
- A new request is accepted one cycle after returning to IDLE.
- Operand changes during CALC are ignored, since operands are latched.

Decomposition:
- Shared package/header pcpi_defs holds:
  - OPC_CUSTOM0, F7_APPROX, F3_MULA, F3_MULHUA
  - state encoding IDLE/CALC/DONE (2-bit)
- One sub-module, approx_mul_core: masking plus iterative shift-add datapath.
  - Inputs: start, a, b.
  - Outputs: busy, done, 64-bit product.
- The top level holds decode, FSM and PCPI handshake only.

Test Plan:
- TRUNC=4, MULA, rs1=0x00001234, rs2=0x00000010 → wait high from cycle 1; ready+wr at cycle 29; rd=0x00012300 (exact would be 0x00012340).
- TRUNC=4, MULHUA, rs1=rs2=0xFFFFFFFF → rd=0xFFFFFFE0. Same operands with MULA → rd=0x00000100.
- TRUNC=0, STEP=4, MULA then MULHUA, rs1=rs2=0x00010001 → rd=0x00020001 then 0x00000001; ready at cycle 9.
- insn funct3=3'b001 (or opcode 0110011) with valid held 20 cycles → wait and ready never assert.
- Valid dropped at cycle 10 of CALC → no ready; wait low by cycle 12. A following legal request completes with the correct result.
- reset asserted at cycle 5 of CALC → all outputs 0 next edge, state IDLE. After release, a fresh request completes normally.
